// File: rtl/cpu7_ifu_iq_pkg.sv
// Shared widths and payload types for the IFU->EXU issue queue and its e/m/w PC tracker.
package cpu7_ifu_iq_pkg;

   localparam int unsigned GRLEN     = 32;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned EXCCODE_W = 6;

   // One queue entry; fields packed MSB-first as pc, inst, exception, exccode.
   typedef struct packed {
      logic [GRLEN-1:0]     pc;
      logic [INST_W-1:0]    inst;
      logic                 exception;
      logic [EXCCODE_W-1:0] exccode;
   } iq_entry_t;

   typedef struct packed {
      logic             valid;
      logic [GRLEN-1:0] pc;
   } trk_stage_t;

endpackage

// File: rtl/cpu7_ifu_iq_trk.sv
// Follows issued PCs through the e/m/w stages; the whole pipe freezes while the EXU stalls.
module cpu7_ifu_iq_trk
   import cpu7_ifu_iq_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             stall,
   input  logic             issue_valid,
   input  logic [GRLEN-1:0] issue_pc,
   output logic             valid_w,
   output logic [GRLEN-1:0] pc_w
);

   trk_stage_t e_q, m_q, w_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (!stall) begin
         e_q <= '{valid: issue_valid, pc: issue_pc};
         m_q <= e_q;
         w_q <= m_q;
      end
   end

   assign valid_w = w_q.valid;
   assign pc_w    = w_q.pc;

endmodule

// File: rtl/cpu7_ifu_iq.sv
// IFU->EXU instruction issue queue with e/m/w PC tracking.
// Optional zero-latency empty-queue bypass is enabled by defining CPU7_IQ_BYPASS_EN.
module cpu7_ifu_iq
   import cpu7_ifu_iq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 fdp_iq_valid,
   input  logic [GRLEN-1:0]     fdp_iq_pc,
   input  logic [INST_W-1:0]    fdp_iq_inst,
   input  logic                 fdp_iq_exception,
   input  logic [EXCCODE_W-1:0] fdp_iq_exccode,
   output logic                 iq_fdp_ready,
   input  logic                 exu_ifu_stall,
   input  logic                 exu_ifu_flush,
   output logic                 ifu_exu_valid,
   output logic [GRLEN-1:0]     ifu_exu_pc,
   output logic [INST_W-1:0]    ifu_exu_inst,
   output logic                 ifu_exu_exception,
   output logic [EXCCODE_W-1:0] ifu_exu_exccode,
   output logic [GRLEN-1:0]     ifu_exu_pc_w,
   output logic                 ifu_exu_valid_w
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   iq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rptr, wptr;
   logic [CNT_W-1:0] count;
   iq_entry_t        fdp_entry, out_entry;
   logic             q_valid, bypass, push_req, q_push, q_pop, issue;

   assign fdp_entry = '{pc: fdp_iq_pc, inst: fdp_iq_inst,
                        exception: fdp_iq_exception, exccode: fdp_iq_exccode};

   // Ready looks only at the registered count, so a full queue refuses even when popping.
   assign q_valid      = (count != '0);
   assign iq_fdp_ready = (count < CNT_W'(DEPTH));
   assign push_req     = fdp_iq_valid && iq_fdp_ready && !exu_ifu_flush;

`ifdef CPU7_IQ_BYPASS_EN
   assign bypass = !q_valid && fdp_iq_valid && !exu_ifu_flush;
`else
   assign bypass = 1'b0;
`endif

   assign ifu_exu_valid = q_valid || bypass;
   assign issue         = ifu_exu_valid && !exu_ifu_stall;
   assign q_pop         = issue && q_valid;
   // A bypassed instruction that issues immediately never occupies an entry.
   assign q_push        = push_req && !(bypass && !exu_ifu_stall);

   // Payload reads as zero whenever nothing is presented (reset, empty, post-flush).
   always_comb begin
      out_entry = '0;
      if (bypass)       out_entry = fdp_entry;
      else if (q_valid) out_entry = mem[rptr];
   end

   assign ifu_exu_pc        = out_entry.pc;
   assign ifu_exu_inst      = out_entry.inst;
   assign ifu_exu_exception = out_entry.exception;
   assign ifu_exu_exccode   = out_entry.exccode;

   // Pointer/count control; flush wins over push and pop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (exu_ifu_flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (q_push) wptr <= wptr + PTR_W'(1);
         if (q_pop)  rptr <= rptr + PTR_W'(1);
         if (q_push && !q_pop)      count <= count + CNT_W'(1);
         else if (q_pop && !q_push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (q_push) mem[wptr] <= fdp_entry;
   end

   cpu7_ifu_iq_trk u_trk (
      .clk         (clk),
      .resetn      (resetn),
      .stall       (exu_ifu_stall),
      .issue_valid (issue),
      .issue_pc    (ifu_exu_pc),
      .valid_w     (ifu_exu_valid_w),
      .pc_w        (ifu_exu_pc_w)
   );

endmodule

// File: tb/tb_cpu7_ifu_iq.sv
// Scoreboard bench for cpu7_ifu_iq: directed scenarios followed by randomized traffic.
module tb_cpu7_ifu_iq;
   import cpu7_ifu_iq_pkg::*;

   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 fdp_iq_valid = 1'b0;
   logic [GRLEN-1:0]     fdp_iq_pc = '0;
   logic [31:0]          fdp_iq_inst = '0;
   logic                 fdp_iq_exception = 1'b0;
   logic [5:0]           fdp_iq_exccode = '0;
   logic                 iq_fdp_ready;
   logic                 exu_ifu_stall = 1'b0;
   logic                 exu_ifu_flush = 1'b0;
   logic                 ifu_exu_valid;
   logic [GRLEN-1:0]     ifu_exu_pc;
   logic [31:0]          ifu_exu_inst;
   logic                 ifu_exu_exception;
   logic [5:0]           ifu_exu_exccode;
   logic [GRLEN-1:0]     ifu_exu_pc_w;
   logic                 ifu_exu_valid_w;

   cpu7_ifu_iq #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .fdp_iq_valid      (fdp_iq_valid),
      .fdp_iq_pc         (fdp_iq_pc),
      .fdp_iq_inst       (fdp_iq_inst),
      .fdp_iq_exception  (fdp_iq_exception),
      .fdp_iq_exccode    (fdp_iq_exccode),
      .iq_fdp_ready      (iq_fdp_ready),
      .exu_ifu_stall     (exu_ifu_stall),
      .exu_ifu_flush     (exu_ifu_flush),
      .ifu_exu_valid     (ifu_exu_valid),
      .ifu_exu_pc        (ifu_exu_pc),
      .ifu_exu_inst      (ifu_exu_inst),
      .ifu_exu_exception (ifu_exu_exception),
      .ifu_exu_exccode   (ifu_exu_exccode),
      .ifu_exu_pc_w      (ifu_exu_pc_w),
      .ifu_exu_valid_w   (ifu_exu_valid_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [GRLEN-1:0] pc;
      logic [31:0]      inst;
      logic             exc;
      logic [5:0]       code;
   } ent_t;

   // Reference model: FIFO of accepted instructions, and retiring PCs keyed by advance count.
   ent_t             exp_q[$];
   logic [GRLEN-1:0] trk_pc [int];
   int               adv_cnt = 0;
   int               checks  = 0;
   int               errors  = 0;
   logic [GRLEN-1:0] pc_seq  = 32'h1c00_1000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One fetch/EXU cycle; called at posedge+1, returns at the next posedge+1.
   task automatic drive(input logic v, input logic [GRLEN-1:0] pc, input logic [31:0] inst,
                        input logic exc, input logic [5:0] code,
                        input logic stall, input logic flush);
      ent_t e;
      logic acc;
      fdp_iq_valid     = v;
      fdp_iq_pc        = pc;
      fdp_iq_inst      = inst;
      fdp_iq_exception = exc;
      fdp_iq_exccode   = code;
      exu_ifu_stall    = stall;
      exu_ifu_flush    = flush;
      chk("ready", iq_fdp_ready, 64'(exp_q.size() < DEPTH));
      acc = v && !flush && (exp_q.size() < DEPTH);
      e = '{pc, inst, exc, code};
`ifdef CPU7_IQ_BYPASS_EN
      if (acc) exp_q.push_back(e);
`endif
      @(posedge clk);
      if (resetn) begin
         if (flush) exp_q.delete();
`ifndef CPU7_IQ_BYPASS_EN
         else if (acc) exp_q.push_back(e);
`endif
      end
      #1;
   endtask

   task automatic idle(input logic stall);
      drive(1'b0, '0, '0, 1'b0, '0, stall, 1'b0);
   endtask

   task automatic push(input logic [GRLEN-1:0] pc, input logic stall);
      drive(1'b1, pc, $urandom, 1'b0, '0, stall, 1'b0);
   endtask

   // Monitor: compares presented outputs against the model head and retires on issue.
   always @(negedge clk) begin
      if (resetn) begin
         chk("issue_valid", ifu_exu_valid, 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("issue_pc",   ifu_exu_pc,        exp_q[0].pc);
            chk("issue_inst", ifu_exu_inst,      exp_q[0].inst);
            chk("issue_exc",  ifu_exu_exception, exp_q[0].exc);
            chk("issue_code", ifu_exu_exccode,   exp_q[0].code);
         end
         chk("valid_w", ifu_exu_valid_w, 64'(trk_pc.exists(adv_cnt)));
         if (trk_pc.exists(adv_cnt)) chk("pc_w", ifu_exu_pc_w, trk_pc[adv_cnt]);
         if (!exu_ifu_stall) begin
            if (exp_q.size() != 0) begin
               trk_pc[adv_cnt + 3] = exp_q[0].pc;
               void'(exp_q.pop_front());
            end
            adv_cnt++;
         end
      end
   end

   initial begin
      logic [GRLEN-1:0] p;
      logic             v, s, f, x;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid",   ifu_exu_valid,     0);
      chk("reset_pc",      ifu_exu_pc,        0);
      chk("reset_inst",    ifu_exu_inst,      0);
      chk("reset_exc",     ifu_exu_exception, 0);
      chk("reset_code",    ifu_exu_exccode,   0);
      chk("reset_valid_w", ifu_exu_valid_w,   0);
      chk("reset_pc_w",    ifu_exu_pc_w,      0);
      chk("reset_ready",   iq_fdp_ready,      1);
      resetn = 1'b1;
      idle(1'b0);

      // Fill to full under stall, offer a refused fifth push, then drain in order.
      for (int i = 0; i < 4; i++) push(32'h1c00_0000 + 32'(4 * i), 1'b1);
      chk("full_ready", iq_fdp_ready, 0);
      push(32'h1c00_0010, 1'b1);
      repeat (6) idle(1'b0);

      // Steady push/pop at count=2 across two pointer wraps.
      push(32'h1c00_0200, 1'b1);
      push(32'h1c00_0204, 1'b1);
      for (int i = 0; i < 8; i++) push(32'h1c00_0208 + 32'(4 * i), 1'b0);
      repeat (4) idle(1'b0);

      // Flush with a concurrent push at count=3 while an earlier issue is in flight.
      push(32'h1c00_0300, 1'b1);
      push(32'h1c00_0304, 1'b1);
      push(32'h1c00_0308, 1'b0);
      push(32'h1c00_030c, 1'b1);
      drive(1'b1, 32'h1c00_0100, 32'h1234_5678, 1'b0, '0, 1'b1, 1'b1);
      fdp_iq_valid  = 1'b0;
      exu_ifu_flush = 1'b0;
      exu_ifu_stall = 1'b0;
      chk("flush_valid", ifu_exu_valid, 0);
      repeat (6) idle(1'b0);

      // Tracker: issue stall-free, then two stall cycles before retirement.
      push(32'h1c00_0000, 1'b0);
`ifdef CPU7_IQ_BYPASS_EN
      idle(1'b0);
      idle(1'b0);
`else
      idle(1'b0);
`endif
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      chk("trk_not_yet", ifu_exu_valid_w, 0);
      idle(1'b0);
      chk("trk_valid_w", ifu_exu_valid_w, 1);
      chk("trk_pc_w",    ifu_exu_pc_w,    32'h1c00_0000);
      repeat (3) idle(1'b0);

      // Exception pass-through, held visible under stall.
      drive(1'b1, 32'h1c00_0400, 32'h0000_002b, 1'b1, 6'h08, 1'b1, 1'b0);
      chk("exc_flag", ifu_exu_exception, 1);
      chk("exc_code", ifu_exu_exccode,   6'h08);
      repeat (3) idle(1'b0);

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 3; i++) push(32'h1c00_0500 + 32'(4 * i), 1'b1);
      fdp_iq_valid  = 1'b0;
      exu_ifu_stall = 1'b0;
      #1 resetn = 1'b0;
      #1;
      chk("arst_valid",   ifu_exu_valid,   0);
      chk("arst_valid_w", ifu_exu_valid_w, 0);
      exp_q.delete();
      trk_pc.delete();
      @(posedge clk);
      #1 resetn = 1'b1;
      chk("arst_ready", iq_fdp_ready,  1);
      chk("arst_empty", ifu_exu_valid, 0);
      idle(1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 9) < 7);
         s = ($urandom_range(0, 9) < 3);
         f = ($urandom_range(0, 99) < 3);
         x = ($urandom_range(0, 7) == 0);
         p = pc_seq;
         if (v) pc_seq = pc_seq + 32'd4;
         drive(v, p, $urandom, x, x ? 6'($urandom_range(0, 63)) : 6'd0, s, f);
      end
      repeat (10) idle(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu7_ifu_iq.md
Name: cpu7_ifu_iq

Overview:
Instruction issue queue at the IFU→EXU boundary. It is the transmitting end of the ifu_exu_* interface.
- Buffers fetched instructions (pc, inst, fetch exception) from the fetch datapath.
- Presents one instruction per cycle to the EXU under an EXU stall handshake.
- Tracks issued PCs through the e/m/w stages to drive ifu_exu_pc_w for writeback debug.
- Opcode/immediate decode (cpu7_ifu_dec) is combinational on this block's outputs and is out of scope.

Parameters:
DEPTH, 4, queue entries; power of two, ≥2.
PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
clk  in  1  clock.
resetn  in  1  reset, asynchronous, active-low.
fdp_iq_valid  in  1  fetch offers an instruction.
fdp_iq_pc  in  GRLEN  fetch PC.
fdp_iq_inst  in  32  instruction word.
fdp_iq_exception  in  1  fetch-side exception (e.g. ADEF).
fdp_iq_exccode  in  6  exception code.
iq_fdp_ready  out  1  queue can accept this cycle.
exu_ifu_stall  in  1  EXU not accepting; holds the issue slot and the e/m/w tracker.
exu_ifu_flush  in  1  redirect; discard all queued instructions.
ifu_exu_valid  out  1  issue slot holds a valid instruction.
ifu_exu_pc  out  GRLEN  issued PC.
ifu_exu_inst  out  32  issued instruction.
ifu_exu_exception  out  1  issued fetch exception.
ifu_exu_exccode  out  6  issued exception code.
ifu_exu_pc_w  out  GRLEN  PC of the instruction currently in writeback.
ifu_exu_valid_w  out  1  writeback stage holds an issued instruction.

Behaviour:
- Reset: clk is the single clock; resetn is asynchronous, active-low. All outputs go to 0; pointers, count and e/m/w valids go to 0. Queue payload RAM is not reset.
- Push: fdp_iq_valid && iq_fdp_ready && !exu_ifu_flush. The entry is written at wptr, then wptr++.
- iq_fdp_ready = (count < DEPTH). It is combinational from the registered count and has no dependence on the pop in the same cycle. A full queue therefore refuses a push even when a pop happens that cycle.
- Pop: ifu_exu_valid && !exu_ifu_stall. Then rptr++.
- Output registers: ifu_exu_* are driven from the entry at rptr. ifu_exu_valid = (count != 0).
- Latency (no bypass): a push at cycle N produces ifu_exu_valid=1 at N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH. count has width PTR_W+1 and ranges 0..DEPTH.
- Flush: count, rptr and wptr are cleared. A push in the same cycle is dropped. ifu_exu_valid is 0 in the next cycle. Flush has priority over push and pop.
- Stall: the payload at rptr is held stable while exu_ifu_stall=1. This holds regardless of any pushes into other entries.
- e/m/w tracker: three {valid,pc} stages. They advance only when exu_ifu_stall=0.
  - On advance: e ← {pop, ifu_exu_pc}; m ← e; w ← m.
  - When stalled, all three stages hold.
  - Flush does not clear the tracker; instructions already issued retire normally.
  - ifu_exu_pc_w and ifu_exu_valid_w come from the w stage. With a stall-free pipe, ifu_exu_pc_w equals the PC popped 3 cycles earlier.
- Protocol assertions:
  - fdp_iq_valid with ready=0 is legal; fetch holds.
  - Pop when count=0 cannot occur.

Optional Feature:
CPU7_IQ_BYPASS_EN.
- Defined: when count=0 and fdp_iq_valid && !exu_ifu_flush, the incoming fields drive ifu_exu_* combinationally and ifu_exu_valid=1 in the same cycle.
  - If !exu_ifu_stall, the instruction issues without being written and the pointers are unchanged.
  - If stalled, it is written normally.
  - Zero-cycle latency.
- Undefined: outputs come only from the queue, with one-cycle minimum latency.

Decomposition:
- Shared package / common.vh: GRLEN, exccode width constant (6), IQ entry field offsets.
- One sub-module, cpu7_ifu_iq_trk: the 3-stage e/m/w PC/valid tracker with stall-gated advance.
- Queue storage and control stay in cpu7_ifu_iq.

Test Plan:
- Reset mid-stream: push 3 instructions, then assert resetn=0 asynchronously → ifu_exu_valid and ifu_exu_valid_w drop immediately; after release, count=0 and iq_fdp_ready=1.
- Fill to full: push pc 0x1c000000..0x1c00000c with stall=1 → ready=0 after the 4th push. A 5th offered push is not accepted. Release stall → issue order 0x1c000000, 04, 08, 0c; ready returns 1 cycle after the first pop.
- Simultaneous push/pop at count=2 for 8 cycles → count stays 2; pointers wrap twice with no reordering.
- Flush with concurrent push (pc 0x1c000100) at count=3 → next cycle ifu_exu_valid=0; 0x1c000100 is never issued; tracker retires the previously issued PCs normally.
- Tracker: issue 0x1c000000 stall-free, then stall 2 cycles → ifu_exu_valid_w=1 with pc_w=0x1c000000 at issue+3 without the stall, and at issue+5 with it.
- Exception pass-through: push with exception=1, exccode=0x08 → ifu_exu_exception=1, ifu_exu_exccode=0x08 on issue.
- Bypass build only: empty queue, push with stall=0 → ifu_exu_valid=1 in the same cycle and count stays 0.
